ps2_key_ctrl: RTL and testbench

Key-event controller between the PS/2 byte receiver (`keyboard` datapath) and the six-digit HEX display path. It pops scan-code bytes from the receiver FIFO with a ready/pop handshake. It parses the E0 (extended) and F0 (break) prefixes, tracks the currently held key and the Shift/CapsLock state, and counts distinct key presses. It outputs registered key code, ASCII and press count for the BCD/7-segment decoders.

---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_key_ctrl_if.sv | 11 +
 rtl/scancode_to_ascii.sv | 55 +++++
 rtl/ps2_key_ctrl.sv | 121 ++++++++++++
 tb/tb_ps2_key_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 key-event controller: prefix/modifier scan codes,
// the set of receiver status bytes that carry no key information, and FSM states.
package ps2_pkg;

    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_BRK = 8'hF0;
    localparam logic [7:0] LSHIFT     = 8'h12;
    localparam logic [7:0] RSHIFT     = 8'h59;
    localparam logic [7:0] CAPS       = 8'h58;

    localparam int N_IGNORE = 6;
    localparam logic [7:0] IGNORE_CODES [N_IGNORE] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        GAP    = 2'd2
    } ps2_state_e;

    function automatic logic is_ignore_code(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_IGNORE; i++) begin
            if (b == IGNORE_CODES[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/ps2_key_ctrl_if.sv
// Receiver FIFO handshake. Protocol: data is valid while ready is high; the consumer
// acknowledges one byte by pulling nextdata_n low for exactly one clock cycle.
interface ps2_key_ctrl_if;
    logic       ready;
    logic [7:0] data;
    logic       overflow;
    logic       nextdata_n;

    modport master (output ready, output data, output overflow, input nextdata_n);
    modport slave  (input ready, input data, input overflow, output nextdata_n);
endinterface

// File: rtl/scancode_to_ascii.sv
// Combinational scan-code ROM: lower/upper glyph per make code, then picks one
// using CapsLock only for letters and Shift for everything.
module scancode_to_ascii (
    input  logic [7:0] code,
    input  logic       shift_on,
    input  logic       caps_on,
    output logic [7:0] ascii
);
    logic [7:0] lo_c;
    logic [7:0] up_c;
    logic       letter;

    always_comb begin
        lo_c = 8'h00;
        up_c = 8'h00;
        case (code)
            8'h1C: lo_c = "a";  8'h32: lo_c = "b";  8'h21: lo_c = "c";  8'h23: lo_c = "d";
            8'h24: lo_c = "e";  8'h2B: lo_c = "f";  8'h34: lo_c = "g";  8'h33: lo_c = "h";
            8'h43: lo_c = "i";  8'h3B: lo_c = "j";  8'h42: lo_c = "k";  8'h4B: lo_c = "l";
            8'h3A: lo_c = "m";  8'h31: lo_c = "n";  8'h44: lo_c = "o";  8'h4D: lo_c = "p";
            8'h15: lo_c = "q";  8'h2D: lo_c = "r";  8'h1B: lo_c = "s";  8'h2C: lo_c = "t";
            8'h3C: lo_c = "u";  8'h2A: lo_c = "v";  8'h1D: lo_c = "w";  8'h22: lo_c = "x";
            8'h35: lo_c = "y";  8'h1A: lo_c = "z";
            8'h16: begin lo_c = "1"; up_c = "!"; end
            8'h1E: begin lo_c = "2"; up_c = "@"; end
            8'h26: begin lo_c = "3"; up_c = "#"; end
            8'h25: begin lo_c = "4"; up_c = "$"; end
            8'h2E: begin lo_c = "5"; up_c = "%"; end
            8'h36: begin lo_c = "6"; up_c = "^"; end
            8'h3D: begin lo_c = "7"; up_c = "&"; end
            8'h3E: begin lo_c = "8"; up_c = "*"; end
            8'h46: begin lo_c = "9"; up_c = "("; end
            8'h45: begin lo_c = "0"; up_c = ")"; end
            8'h4E: begin lo_c = "-"; up_c = "_"; end
            8'h55: begin lo_c = "="; up_c = "+"; end
            8'h54: begin lo_c = "["; up_c = "{"; end
            8'h5B: begin lo_c = "]"; up_c = "}"; end
            8'h5D: begin lo_c = "\\"; up_c = "|"; end
            8'h4C: begin lo_c = ";"; up_c = ":"; end
            8'h52: begin lo_c = "'"; up_c = "\""; end
            8'h41: begin lo_c = ","; up_c = "<"; end
            8'h49: begin lo_c = "."; up_c = ">"; end
            8'h4A: begin lo_c = "/"; up_c = "?"; end
            8'h0E: begin lo_c = 8'h60; up_c = "~"; end
            8'h29: begin lo_c = " "; up_c = " "; end
            8'h5A: begin lo_c = 8'h0D; up_c = 8'h0D; end
            default: begin lo_c = 8'h00; up_c = 8'h00; end
        endcase
        letter = (lo_c >= "a") && (lo_c <= "z");
        // Letter upper case differs only in bit 5, so the table stores lower case only.
        if (letter) up_c = lo_c ^ 8'h20;
        if (letter) ascii = (shift_on ^ caps_on) ? up_c : lo_c;
        else        ascii = shift_on ? up_c : lo_c;
    end
endmodule

// File: rtl/ps2_key_ctrl.sv
// Pops scan-code bytes from the PS/2 receiver FIFO, resolves E0/F0 prefixes and
// Shift/CapsLock, and holds the latest key code, ASCII glyph and press count.
module ps2_key_ctrl
    import ps2_pkg::*;
(
    input  logic          CLOCK,
    input  logic          CLRN,
    ps2_key_ctrl_if.slave ps2,
    output logic [7:0]    key_code,
    output logic          key_ext,
    output logic          key_pressed,
    output logic [7:0]    ascii_key,
    output logic [7:0]    key_count,
    output logic          shift_on,
    output logic          caps_on,
    output logic          overflow_err,
    output logic [1:0]    dbg_state
);
    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_DECODE = DECODE;
    localparam logic [1:0] S_GAP    = GAP;

    logic [1:0] state;
    logic [7:0] byte_r;
    logic       ext_f;
    logic       brk_f;
    logic       lshift_r;
    logic       rshift_r;
    logic       nextdata_n_r;
    logic [7:0] rom_ascii;

    logic cur_match;
    logic is_lshift;
    logic is_rshift;
    logic is_caps;
    logic ignore_b;

    assign cur_match = key_pressed && ({ext_f, byte_r} == {key_ext, key_code});
    assign is_lshift = !ext_f && (byte_r == LSHIFT);
    assign is_rshift = !ext_f && (byte_r == RSHIFT);
    assign is_caps   = !ext_f && (byte_r == CAPS);
    assign ignore_b  = !ext_f && !brk_f && is_ignore_code(byte_r);

    assign shift_on       = lshift_r | rshift_r;
    assign ps2.nextdata_n = nextdata_n_r;
    assign dbg_state      = state;

    // Glyph uses the modifier state before the byte being decoded takes effect.
    scancode_to_ascii u_rom (
        .code     (byte_r),
        .shift_on (shift_on),
        .caps_on  (caps_on),
        .ascii    (rom_ascii)
    );

    always_ff @(posedge CLOCK or negedge CLRN) begin
        if (!CLRN) begin
            state        <= S_IDLE;
            byte_r       <= 8'h00;
            ext_f        <= 1'b0;
            brk_f        <= 1'b0;
            lshift_r     <= 1'b0;
            rshift_r     <= 1'b0;
            nextdata_n_r <= 1'b1;
            key_code     <= 8'h00;
            key_ext      <= 1'b0;
            key_pressed  <= 1'b0;
            ascii_key    <= 8'h00;
            key_count    <= 8'h00;
            caps_on      <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ps2.ready) begin
                        byte_r       <= ps2.data;
                        nextdata_n_r <= 1'b0;
                        state        <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    nextdata_n_r <= 1'b1;
                    state        <= S_GAP;
                    if (byte_r == PREFIX_EXT) begin
                        ext_f <= 1'b1;
                    end else if (byte_r == PREFIX_BRK) begin
                        brk_f <= 1'b1;
                    end else if (!ignore_b) begin
                        ext_f <= 1'b0;
                        brk_f <= 1'b0;
                        if (brk_f) begin
                            if (cur_match) key_pressed <= 1'b0;
                            if (is_lshift) lshift_r <= 1'b0;
                            if (is_rshift) rshift_r <= 1'b0;
                        end else begin
                            // A make matching the held key is typematic repeat.
                            if (!cur_match) begin
                                key_code    <= byte_r;
                                key_ext     <= ext_f;
                                key_pressed <= 1'b1;
                                key_count   <= key_count + 8'd1;
                                ascii_key   <= ext_f ? 8'h00 : rom_ascii;
                                if (is_caps) caps_on <= ~caps_on;
                            end
                            if (is_lshift) lshift_r <= 1'b1;
                            if (is_rshift) rshift_r <= 1'b1;
                        end
                    end
                end
                S_GAP:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            // Overflow drops any half-received prefix; placed last so it overrides decode.
            if (ps2.overflow) begin
                overflow_err <= 1'b1;
                ext_f        <= 1'b0;
                brk_f        <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl: a FIFO driver pushes hand-computed expected outputs,
// and a monitor compares them each time the pop strobe completes.
module tb_ps2_key_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    ps2_key_ctrl_if ps2 ();

    logic [7:0] key_code;
    logic       key_ext;
    logic       key_pressed;
    logic [7:0] ascii_key;
    logic [7:0] key_count;
    logic       shift_on;
    logic       caps_on;
    logic       overflow_err;
    logic [1:0] dbg_state;

    ps2_key_ctrl dut (
        .CLOCK        (clk),
        .CLRN         (rst_n),
        .ps2          (ps2),
        .key_code     (key_code),
        .key_ext      (key_ext),
        .key_pressed  (key_pressed),
        .ascii_key    (ascii_key),
        .key_count    (key_count),
        .shift_on     (shift_on),
        .caps_on      (caps_on),
        .overflow_err (overflow_err),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_sent   = 0;
    int n_pops   = 0;
    logic [28:0] exp_q[$];

    logic [28:0] act;
    assign act = {key_code, key_ext, key_pressed, ascii_key, key_count, shift_on, caps_on, overflow_err};

    function automatic logic [28:0] mk(input logic [7:0] code, input logic ext, input logic pr,
                                       input logic [7:0] asc, input logic [7:0] cnt,
                                       input logic sh, input logic cp, input logic ov);
        return {code, ext, pr, asc, cnt, sh, cp, ov};
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        n_checks++;
        if (actual !== required) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    // Receiver model: present one byte, hold it until popped, then let DECODE/GAP pass.
    task automatic send_byte(input logic [7:0] b, input logic [28:0] expv);
        bit popped;
        popped = 1'b0;
        @(negedge clk);
        exp_q.push_back(expv);
        n_sent++;
        ps2.ready = 1'b1;
        ps2.data  = b;
        for (int i = 0; i < 20 && !popped; i++) begin
            @(posedge clk);
            #1;
            if (!ps2.nextdata_n) popped = 1'b1;
        end
        ps2.ready = 1'b0;
        ps2.data  = 8'h00;
        if (!popped) begin
            n_checks++;
            n_fail++;
            $display("FAIL pop_timeout byte=%0h actual=no_pop required=pop", b);
            void'(exp_q.pop_back());
            n_sent--;
        end
        repeat (2) @(posedge clk);
    endtask

    // Monitor: a low-to-high pop strobe marks the edge where decode results land.
    initial begin
        logic prev_n;
        int   low_cycles;
        prev_n     = 1'b1;
        low_cycles = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_n     = 1'b1;
                low_cycles = 0;
            end else begin
                if (!ps2.nextdata_n) begin
                    low_cycles++;
                end else if (!prev_n) begin
                    n_pops++;
                    check("pop_width", low_cycles, 1);
                    if (exp_q.size() == 0) check("unexpected_pop", 1, 0);
                    else check($sformatf("decode%0d", n_pops), {3'b000, act}, {3'b000, exp_q.pop_front()});
                    low_cycles = 0;
                end
                prev_n = ps2.nextdata_n;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit popped;
        ps2.ready    = 1'b0;
        ps2.data     = 8'h00;
        ps2.overflow = 1'b0;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {3'b000, act}, 32'h0);
        check("reset_pop_n", ps2.nextdata_n, 1);
        check("reset_state", dbg_state, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single press, typematic repeat, release
        send_byte(8'h1C, mk(8'h1C, 0, 1, 8'h61, 8'h01, 0, 0, 0));
        send_byte(8'h1C, mk(8'h1C, 0, 1, 8'h61, 8'h01, 0, 0, 0));
        send_byte(8'h1C, mk(8'h1C, 0, 1, 8'h61, 8'h01, 0, 0, 0));
        send_byte(8'hF0, mk(8'h1C, 0, 1, 8'h61, 8'h01, 0, 0, 0));
        send_byte(8'h1C, mk(8'h1C, 0, 0, 8'h61, 8'h01, 0, 0, 0));
        // shift, caps, both
        send_byte(8'h12, mk(8'h12, 0, 1, 8'h00, 8'h02, 1, 0, 0));
        send_byte(8'h1C, mk(8'h1C, 0, 1, 8'h41, 8'h03, 1, 0, 0));
        send_byte(8'hF0, mk(8'h1C, 0, 1, 8'h41, 8'h03, 1, 0, 0));
        send_byte(8'h12, mk(8'h1C, 0, 1, 8'h41, 8'h03, 0, 0, 0));
        send_byte(8'h58, mk(8'h58, 0, 1, 8'h00, 8'h04, 0, 1, 0));
        send_byte(8'hF0, mk(8'h58, 0, 1, 8'h00, 8'h04, 0, 1, 0));
        send_byte(8'h58, mk(8'h58, 0, 0, 8'h00, 8'h04, 0, 1, 0));
        send_byte(8'h1C, mk(8'h1C, 0, 1, 8'h41, 8'h05, 0, 1, 0));
        send_byte(8'h12, mk(8'h12, 0, 1, 8'h00, 8'h06, 1, 1, 0));
        send_byte(8'h1C, mk(8'h1C, 0, 1, 8'h61, 8'h07, 1, 1, 0));
        send_byte(8'h16, mk(8'h16, 0, 1, 8'h21, 8'h08, 1, 1, 0));
        send_byte(8'hF0, mk(8'h16, 0, 1, 8'h21, 8'h08, 1, 1, 0));
        send_byte(8'h12, mk(8'h16, 0, 1, 8'h21, 8'h08, 0, 1, 0));
        send_byte(8'h16, mk(8'h16, 0, 1, 8'h21, 8'h08, 0, 1, 0));
        send_byte(8'h58, mk(8'h58, 0, 1, 8'h00, 8'h09, 0, 0, 0));
        send_byte(8'hF0, mk(8'h58, 0, 1, 8'h00, 8'h09, 0, 0, 0));
        send_byte(8'h58, mk(8'h58, 0, 0, 8'h00, 8'h09, 0, 0, 0));
        // extended key, plain twin counts as a distinct press
        send_byte(8'hE0, mk(8'h58, 0, 0, 8'h00, 8'h09, 0, 0, 0));
        send_byte(8'h75, mk(8'h75, 1, 1, 8'h00, 8'h0A, 0, 0, 0));
        send_byte(8'h75, mk(8'h75, 0, 1, 8'h00, 8'h0B, 0, 0, 0));
        send_byte(8'hE0, mk(8'h75, 0, 1, 8'h00, 8'h0B, 0, 0, 0));
        send_byte(8'h75, mk(8'h75, 1, 1, 8'h00, 8'h0C, 0, 0, 0));
        send_byte(8'hE0, mk(8'h75, 1, 1, 8'h00, 8'h0C, 0, 0, 0));
        send_byte(8'hF0, mk(8'h75, 1, 1, 8'h00, 8'h0C, 0, 0, 0));
        send_byte(8'h75, mk(8'h75, 1, 0, 8'h00, 8'h0C, 0, 0, 0));
        send_byte(8'hAA, mk(8'h75, 1, 0, 8'h00, 8'h0C, 0, 0, 0));

        // alternate 'a'/'b' presses up to a count of 0xFF, then wrap
        for (int i = 0; i < 243; i++) begin
            if (i % 2 == 0) send_byte(8'h1C, mk(8'h1C, 0, 1, 8'h61, 8'(8'h0D + i), 0, 0, 0));
            else            send_byte(8'h32, mk(8'h32, 0, 1, 8'h62, 8'(8'h0D + i), 0, 0, 0));
        end
        send_byte(8'h32, mk(8'h32, 0, 1, 8'h62, 8'h00, 0, 0, 0));

        // overflow during a pending break prefix
        send_byte(8'hF0, mk(8'h32, 0, 1, 8'h62, 8'h00, 0, 0, 0));
        @(negedge clk);
        ps2.overflow = 1'b1;
        @(negedge clk);
        ps2.overflow = 1'b0;
        check("overflow_err_set", overflow_err, 1);
        send_byte(8'h1C, mk(8'h1C, 0, 1, 8'h61, 8'h01, 0, 0, 1));

        // reset while the pop strobe is low
        @(negedge clk);
        ps2.ready = 1'b1;
        ps2.data  = 8'h32;
        popped    = 1'b0;
        for (int i = 0; i < 20 && !popped; i++) begin
            @(posedge clk);
            #1;
            if (!ps2.nextdata_n) popped = 1'b1;
        end
        check("midpop_strobe_low", popped, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_pop_n", ps2.nextdata_n, 1);
        check("async_rst_outputs", {3'b000, act}, 32'h0);
        check("async_rst_state", dbg_state, 0);
        ps2.ready = 1'b0;
        ps2.data  = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("no_decode_after_rst", {3'b000, act}, 32'h0);
        check("idle_after_rst", dbg_state, 0);

        check("pop_count", n_pops, n_sent);
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
